// File: rtl/counter_nbit_updown_pkg.sv
// Shared definitions for the cascadable up/down counter.
//   DIR_*      : meaning of the 'up' input
//   MODE_*     : meaning of the 'sat' input
//   cnt_op_t   : per-edge operation chosen by the counter's mode decode
//   clamp_val  : largest legal count (MODULUS-1), truncated by the caller to WIDTH bits
package counter_nbit_updown_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_STEP,
        OP_WRAP,
        OP_SAT
    } cnt_op_t;

    // MODULUS may be 2**32 when WIDTH is 32, so it travels as a 64-bit value.
    function automatic logic [31:0] clamp_val(input longint unsigned modulus);
        return 32'(modulus - 64'd1);
    endfunction

endpackage

// File: rtl/counter_nbit_updown_tc_detect.sv
// Terminal-count detector for the up/down counter.
//   q  : current count
//   up : direction (DIR_UP / DIR_DOWN)
//   en : count enable / carry-in
//   tc : q sits at the terminal value for the current direction
//   rc : ripple carry/borrow (en && tc), zero latency, feeds the next stage's en
module counter_tc_detect
    import counter_nbit_updown_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    output logic             tc,
    output logic             rc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(clamp_val(MODULUS));

    assign tc = (up == DIR_UP) ? (q == MAX_Q) : (q == '0);
    assign rc = en & tc;

endmodule

// File: rtl/counter_nbit_updown.sv
// Parametrised cascadable up/down counter with programmable modulus.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (q=RESET_VAL, ovf=0)
//   en      : count enable / carry-in from a previous stage
//   up      : 1 = increment, 0 = decrement
//   sat     : 0 = wrap at terminal count, 1 = hold at terminal count
//   load    : synchronous parallel load of d (clamped to MODULUS-1)
//   d       : parallel load value
//   clr_ovf : synchronous clear of ovf (a same-cycle overflow event wins)
//   q       : registered count, always within 0..MODULUS-1
//   rc      : combinational ripple carry/borrow
//   ovf     : sticky wrap/saturate flag
module counter_nbit_updown
    import counter_nbit_updown_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             rc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(clamp_val(MODULUS));
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
            MODULUS > (64'd1 << WIDTH) || RESET_VAL >= MODULUS) begin : g_bad_params
            $error("counter_nbit_updown: illegal WIDTH/MODULUS/RESET_VAL combination");
        end
    endgenerate

    logic             tc;
    cnt_op_t          op;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;
    logic             ovf_set;

    counter_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc (
        .q  (q),
        .up (up),
        .en (en),
        .tc (tc),
        .rc (rc)
    );

    // Mode decode: load beats counting; at terminal count the sat input
    // chooses between wrapping and holding.
    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            if (!tc) begin
                op = OP_STEP;
            end else if (sat == MODE_SAT) begin
                op = OP_SAT;
            end else begin
                op = OP_WRAP;
            end
        end
    end

    always_comb begin
        q_next = q;
        case (op)
            OP_LOAD: q_next = (d > MAX_Q) ? MAX_Q : d;
            // tc=0 here, so the step never leaves 0..MODULUS-1.
            OP_STEP: q_next = (up == DIR_UP) ? (q + ONE) : (q - ONE);
            OP_WRAP: q_next = (up == DIR_UP) ? '0 : MAX_Q;
            OP_SAT:  q_next = q;
            OP_HOLD: q_next = q;
            default: q_next = q;
        endcase
    end

    assign ovf_set  = (op == OP_WRAP) || (op == OP_SAT);
    assign ovf_next = ovf_set | (ovf & ~clr_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RST_Q;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_counter_nbit_updown.sv
`timescale 1ns/1ps
module tb_counter_nbit_updown;

    localparam int W = 4;
    localparam longint unsigned M = 10;

    logic         clk = 1'b0;
    logic         rst, en, up, sat, load, clr_ovf;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         rc, ovf;

    logic         rst_c, en_c;
    logic [W-1:0] q0, q1;
    logic         rc0, rc1, ovf0, ovf1;

    int n_total = 0;
    int n_bad   = 0;

    always #50 clk = ~clk;

    counter_nbit_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .clr_ovf(clr_ovf), .q(q), .rc(rc), .ovf(ovf)
    );

    counter_nbit_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) c_ones (
        .clk(clk), .rst(rst_c), .en(en_c), .up(1'b1), .sat(1'b0), .load(1'b0),
        .d(4'd0), .clr_ovf(1'b0), .q(q0), .rc(rc0), .ovf(ovf0)
    );

    counter_nbit_updown #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) c_tens (
        .clk(clk), .rst(rst_c), .en(rc0), .up(1'b1), .sat(1'b0), .load(1'b0),
        .d(4'd0), .clr_ovf(1'b0), .q(q1), .rc(rc1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sat_q[5];
        logic       sat_ovf[5];
        logic       sat_rc[5];
        int         pulses;

        sat_q   = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        sat_ovf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        sat_rc  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; en = 1'b0; up = 1'b0; sat = 1'b0; load = 1'b0;
        d = 4'd0; clr_ovf = 1'b0; rst_c = 1'b1; en_c = 1'b0;
        #20;
        rst = 1'b0;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_rc", 32'(rc), 32'd0);

        // mid-count async reset
        up = 1'b1; en = 1'b1;
        repeat (7) tick();
        chk("pre_reset_q7", 32'(q), 32'd7);
        rst = 1'b1;
        #1;
        chk("async_reset_q", 32'(q), 32'd0);
        chk("async_reset_ovf", 32'(ovf), 32'd0);
        #248;
        rst = 1'b0;
        tick();
        chk("first_count_after_reset", 32'(q), 32'd1);

        // up wrap
        en = 1'b0;
        rst = 1'b1; #1; rst = 1'b0;
        chk("rezero_q", 32'(q), 32'd0);
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("wrap_rc_%0d", i), 32'(rc), 32'(((i - 1) % 10) == 9));
            tick();
            chk($sformatf("wrap_q_%0d", i), 32'(q), 32'(i % 10));
            chk($sformatf("wrap_ovf_%0d", i), 32'(ovf), 32'(i >= 10));
        end

        // down saturate
        en = 1'b0; load = 1'b1; d = 4'd2; clr_ovf = 1'b1; sat = 1'b1; up = 1'b0;
        tick();
        load = 1'b0; clr_ovf = 1'b0;
        chk("sat_load_q", 32'(q), 32'd2);
        chk("sat_load_ovf", 32'(ovf), 32'd0);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("sat_rc_%0d", k), 32'(rc), 32'(sat_rc[k]));
            tick();
            chk($sformatf("sat_q_%0d", k), 32'(q), 32'(sat_q[k]));
            chk($sformatf("sat_ovf_%0d", k), 32'(ovf), 32'(sat_ovf[k]));
        end

        // load clamp and priority
        en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b1; d = 4'hE;
        tick();
        chk("clamp_q", 32'(q), 32'd9);
        chk("clamp_ovf_kept", 32'(ovf), 32'd1);
        load = 1'b0; en = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_hold_q", 32'(q), 32'd9);
        load = 1'b1; d = 4'hE; en = 1'b1; up = 1'b1;
        tick();
        chk("load_at_tc_q", 32'(q), 32'd9);
        chk("load_no_ovf", 32'(ovf), 32'd0);
        d = 4'd3; rst = 1'b1;
        #1;
        chk("rst_over_load_async", 32'(q), 32'd0);
        tick();
        chk("rst_over_load_edge", 32'(q), 32'd0);
        rst = 1'b0; load = 1'b0; en = 1'b0;

        // ovf set/clear collision
        load = 1'b1; d = 4'd9;
        tick();
        load = 1'b0;
        chk("coll_load_q", 32'(q), 32'd9);
        en = 1'b1; up = 1'b1; sat = 1'b0; clr_ovf = 1'b1;
        tick();
        chk("coll_q", 32'(q), 32'd0);
        chk("coll_ovf_set_wins", 32'(ovf), 32'd1);
        en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        chk("coll_ovf_cleared", 32'(ovf), 32'd0);
        chk("coll_hold_q", 32'(q), 32'd0);

        // direction change re-evaluates rc immediately
        en = 1'b1; up = 1'b1;
        #1;
        chk("dir_up_rc", 32'(rc), 32'd0);
        up = 1'b0;
        #1;
        chk("dir_down_rc", 32'(rc), 32'd1);
        en = 1'b0;

        // two-stage cascade
        rst_c = 1'b0;
        #1;
        en_c = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (rc1) pulses++;
            if (e == 37) begin
                chk("casc37_ones", 32'(q0), 32'd7);
                chk("casc37_tens", 32'(q1), 32'd3);
            end
            if (e == 99) begin
                chk("casc99_rc1", 32'(rc1), 32'd1);
                chk("casc99_tens_ovf", 32'(ovf1), 32'd0);
            end
        end
        chk("casc100_ones", 32'(q0), 32'd0);
        chk("casc100_tens", 32'(q1), 32'd0);
        chk("casc100_tens_ovf", 32'(ovf1), 32'd1);
        chk("casc_rc1_pulses", 32'(pulses), 32'd1);
        en_c = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
